// File: rtl/ticker_pkg.sv
// Shared constants, config request type and period helper for multi_divisor_ticker.
package ticker_pkg;

    localparam int TICKER_NUM_CH    = 4;
    localparam int TICKER_DIV_W     = 8;
    localparam int TICKER_CNT_W     = 8;
    localparam int TICKER_RESET_DIV = 3;
    localparam int TICKER_CH_W      = 4;

    typedef struct packed {
        logic [TICKER_CH_W-1:0]  ch;
        logic [TICKER_DIV_W-1:0] div;
    } cfg_req_t;

    // A programmed period of 0 stands for the full counter range.
    function automatic logic [32:0] eff_period(input logic [31:0] period, input int unsigned cnt_w);
        if (period == 32'd0) begin
            return 33'd1 << cnt_w;
        end
        return {1'b0, period};
    endfunction

endpackage

// File: rtl/multi_divisor_ticker_if.sv
// Divisor update valid/ready port of multi_divisor_ticker.
interface multi_divisor_ticker_if import ticker_pkg::*; #(
    parameter int NUM_CH = TICKER_NUM_CH,
    parameter int DIV_W  = TICKER_DIV_W
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;

    modport master (output cfg_valid, output cfg_ch, output cfg_div, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_ch, input cfg_div, output cfg_ready);
endinterface

// File: rtl/ticker_channel.sv
// One ticker channel: divisor register plus phase counter. Optional sticky hit
// flag when TICKER_STICKY_EN is defined.
module ticker_channel import ticker_pkg::*; #(
    parameter int DIV_W     = TICKER_DIV_W,
    parameter int RESET_DIV = TICKER_RESET_DIV
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             wrap,
    input  logic             commit,
    input  logic [DIV_W-1:0] commit_div,
    output logic             hit,
    output logic             div_nz
`ifdef TICKER_STICKY_EN
    ,
    input  logic             sticky_clr,
    output logic             hit_sticky
`endif
);
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] phase_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_q   <= DIV_W'(RESET_DIV);
            phase_q <= '0;
        end else if (en) begin
            if (wrap || (phase_q == div_q - DIV_W'(1))) begin
                phase_q <= '0;
            end else begin
                phase_q <= phase_q + DIV_W'(1);
            end
            // commit is already qualified with wrap by the top level
            if (commit) begin
                div_q <= commit_div;
            end
        end
    end

    assign div_nz = |div_q;
    assign hit    = div_nz && (phase_q == '0);

`ifdef TICKER_STICKY_EN
    always_ff @(posedge clk) begin
        if (!resetn || sticky_clr) begin
            hit_sticky <= 1'b0;
        end else if (en && hit) begin
            hit_sticky <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/multi_divisor_ticker.sv
// N-channel periodic tick generator with wrap-coherent divisor updates.
// Define TICKER_STICKY_EN to add sticky_clr / hit_sticky.
module multi_divisor_ticker import ticker_pkg::*; #(
    parameter int NUM_CH    = TICKER_NUM_CH,
    parameter int DIV_W     = TICKER_DIV_W,
    parameter int CNT_W     = TICKER_CNT_W,
    parameter int RESET_DIV = TICKER_RESET_DIV
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 en,
    input  logic [CNT_W-1:0]     period,
    multi_divisor_ticker_if.slave cfg,
    output logic [CNT_W-1:0]     count,
    output logic                 wrap,
    output logic [NUM_CH-1:0]    hit,
    output logic                 all_hit
`ifdef TICKER_STICKY_EN
    ,
    input  logic                 sticky_clr,
    output logic [NUM_CH-1:0]    hit_sticky
`endif
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              pending;
    logic [CH_W-1:0]   shadow_ch;
    logic [DIV_W-1:0]  shadow_div;
    logic [NUM_CH-1:0] div_nz;
    logic              take;

    // >= rather than == so a period shrunk below count wraps immediately
    assign wrap = en && (33'(count) >= eff_period(32'(period), CNT_W) - 33'd1);

    assign cfg.cfg_ready = !pending;
    assign take          = cfg.cfg_valid && !pending;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pending    <= 1'b0;
            shadow_ch  <= '0;
            shadow_div <= '0;
        end else if (wrap && pending) begin
            pending <= 1'b0;
        end else if (take) begin
            pending    <= 1'b1;
            shadow_ch  <= cfg.cfg_ch;
            shadow_div <= cfg.cfg_div;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ticker_channel #(
            .DIV_W     (DIV_W),
            .RESET_DIV (RESET_DIV)
        ) u_ch (
            .clk        (clk),
            .resetn     (resetn),
            .en         (en),
            .wrap       (wrap),
            .commit     (wrap && pending && (shadow_ch == CH_W'(g))),
            .commit_div (shadow_div),
            .hit        (hit[g]),
            .div_nz     (div_nz[g])
`ifdef TICKER_STICKY_EN
            ,
            .sticky_clr (sticky_clr),
            .hit_sticky (hit_sticky[g])
`endif
        );
    end

    assign all_hit = (|div_nz) && (&(hit | ~div_nz));

endmodule

// File: tb/tb_multi_divisor_ticker.sv
// Self-checking bench for multi_divisor_ticker: vector table, directed corner
// sequences and randomized traffic against an arithmetic reference model.
module tb_multi_divisor_ticker;
    import ticker_pkg::*;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int CW  = 8;
    localparam int RD  = 3;

    logic           clk = 1'b0;
    logic           resetn;
    logic           en;
    logic [CW-1:0]  period;
    logic [CW-1:0]  count;
    logic           wrap;
    logic [NCH-1:0] hit;
    logic           all_hit;
    logic           sc_r;
`ifdef TICKER_STICKY_EN
    logic           sticky_clr;
    logic [NCH-1:0] hit_sticky;
`endif

    always #5 clk = ~clk;

    multi_divisor_ticker_if #(.NUM_CH(NCH), .DIV_W(DW)) cfg_bus ();

    multi_divisor_ticker #(
        .NUM_CH(NCH), .DIV_W(DW), .CNT_W(CW), .RESET_DIV(RD)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .en      (en),
        .period  (period),
        .cfg     (cfg_bus),
        .count   (count),
        .wrap    (wrap),
        .hit     (hit),
        .all_hit (all_hit)
`ifdef TICKER_STICKY_EN
        ,
        .sticky_clr (sticky_clr),
        .hit_sticky (hit_sticky)
`endif
    );

    int errors = 0;
    int checks = 0;

    // reference model: hit is simply count mod div, since phases restart with count
    int             m_count;
    int             m_div[NCH];
    cfg_req_t       m_q[$];
    logic [NCH-1:0] m_sticky;

    int cur_en;
    int cur_period;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_wrap();
        int eff;
        eff = (period == '0) ? (1 << CW) : int'(period);
        return en && (m_count >= eff - 1);
    endfunction

    function automatic logic [NCH-1:0] m_hit();
        logic [NCH-1:0] h;
        for (int i = 0; i < NCH; i++) begin
            h[i] = (m_div[i] != 0) && ((m_count % m_div[i]) == 0);
        end
        return h;
    endfunction

    function automatic bit m_all();
        bit any_on;
        bit all_ok;
        logic [NCH-1:0] h;
        h = m_hit();
        any_on = 0;
        all_ok = 1;
        for (int i = 0; i < NCH; i++) begin
            if (m_div[i] != 0) begin
                any_on = 1;
                if (!h[i]) all_ok = 0;
            end
        end
        return any_on && all_ok;
    endfunction

    task automatic model_check();
        check("count", 32'(count), 32'(m_count));
        check("wrap", 32'(wrap), 32'(m_wrap()));
        check("hit", 32'(hit), 32'(m_hit()));
        check("all_hit", 32'(all_hit), 32'(m_all()));
        check("cfg_ready", 32'(cfg_bus.cfg_ready), 32'(m_q.size() == 0));
`ifdef TICKER_STICKY_EN
        check("hit_sticky", 32'(hit_sticky), 32'(m_sticky));
`endif
    endtask

    task automatic model_step();
        bit w;
        logic [NCH-1:0] h;
        cfg_req_t r;
        if (!resetn) begin
            m_count = 0;
            foreach (m_div[i]) m_div[i] = RD;
            m_q.delete();
            m_sticky = '0;
            return;
        end
        w = m_wrap();
        h = m_hit();
        if (sc_r) m_sticky = '0;
        else if (en) m_sticky = m_sticky | h;
        if (en) m_count = w ? 0 : m_count + 1;
        if (w && m_q.size() > 0) begin
            r = m_q.pop_front();
            if (int'(r.ch) < NCH) m_div[r.ch] = int'(r.div);
        end else if (cfg_bus.cfg_valid && m_q.size() == 0) begin
            r.ch  = 4'(cfg_bus.cfg_ch);
            r.div = cfg_bus.cfg_div;
            m_q.push_back(r);
        end
    endtask

    task automatic apply(input bit rn, input bit e, input int p, input bit v,
                         input int ch, input int d, input bit sc);
        resetn            = rn;
        en                = e;
        period            = CW'(p);
        cfg_bus.cfg_valid = v;
        cfg_bus.cfg_ch    = 2'(ch);
        cfg_bus.cfg_div   = DW'(d);
        sc_r              = sc;
`ifdef TICKER_STICKY_EN
        sticky_clr        = sc;
`endif
        #1;
        if (rn) model_check();
    endtask

    task automatic idle();
        apply(1, cur_en[0], cur_period, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // leaves the bench in the low phase of the cycle where count == target
    task automatic wait_count(input int target);
        for (int k = 0; k < 600; k++) begin
            idle();
            if (32'(count) == 32'(target)) return;
            step();
        end
        check("wait_count_timeout", 32'(count), 32'(target));
    endtask

    typedef struct {
        int             exp_count;
        logic [NCH-1:0] exp_hit;
        bit             exp_wrap;
        bit             exp_all;
    } vec_t;

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{0,  4'hF, 0, 1};
        tbl[1]  = '{1,  4'h0, 0, 0};
        tbl[2]  = '{2,  4'h0, 0, 0};
        tbl[3]  = '{3,  4'hF, 0, 1};
        tbl[4]  = '{4,  4'h0, 0, 0};
        tbl[5]  = '{5,  4'h0, 0, 0};
        tbl[6]  = '{6,  4'hF, 0, 1};
        tbl[7]  = '{7,  4'h0, 0, 0};
        tbl[8]  = '{8,  4'h0, 0, 0};
        tbl[9]  = '{9,  4'hF, 0, 1};
        tbl[10] = '{10, 4'h0, 0, 0};
        tbl[11] = '{11, 4'h0, 0, 0};
        tbl[12] = '{12, 4'hF, 0, 1};
        tbl[13] = '{13, 4'h0, 0, 0};
        tbl[14] = '{14, 4'h0, 1, 0};
        tbl[15] = '{0,  4'hF, 0, 1};

        cur_en = 1;
        cur_period = 15;
        apply(0, 1, 15, 0, 0, 0, 0);
        step();

        // free-running period 15, all channels div 3
        for (int i = 0; i < 16; i++) begin
            idle();
            check("tbl_count", 32'(count), 32'(tbl[i].exp_count));
            check("tbl_hit", 32'(hit), 32'(tbl[i].exp_hit));
            check("tbl_wrap", 32'(wrap), 32'(tbl[i].exp_wrap));
            check("tbl_all_hit", 32'(all_hit), 32'(tbl[i].exp_all));
            check("tbl_ready", 32'(cfg_bus.cfg_ready), 32'd1);
            step();
        end

        // ch1 -> div 5 requested mid-period
        wait_count(4);
        apply(1, 1, 15, 1, 1, 5, 0);
        step();
        idle();
        check("t2_ready_low", 32'(cfg_bus.cfg_ready), 32'd0);
        wait_count(6);
        check("t2_old_div_hit1", 32'(hit[1]), 32'd1);
        wait_count(0);
        check("t2_ready_back", 32'(cfg_bus.cfg_ready), 32'd1);
        check("t2_hit1_c0", 32'(hit[1]), 32'd1);
        wait_count(3);
        check("t2_hit_c3", 32'(hit), 32'b1101);
        wait_count(5);
        check("t2_hit1_c5", 32'(hit[1]), 32'd1);
        wait_count(10);
        check("t2_hit1_c10", 32'(hit[1]), 32'd1);

        // ch2 -> div 0, then div 1
        wait_count(2);
        apply(1, 1, 15, 1, 2, 0, 0);
        step();
        wait_count(0);
        check("t3_hit2_off", 32'(hit[2]), 32'd0);
        check("t3_all_hit_ignores", 32'(all_hit), 32'd1);
        apply(1, 1, 15, 1, 2, 1, 0);
        step();
        wait_count(4);
        check("t3_hit2_still_off", 32'(hit[2]), 32'd0);
        wait_count(0);
        check("t3_hit2_on_c0", 32'(hit[2]), 32'd1);
        step();
        idle();
        check("t3_hit2_on_c1", 32'(hit[2]), 32'd1);
        check("t3_all_hit_c1", 32'(all_hit), 32'd0);

        // en low for 7 cycles at count 8 with a config in the window
        wait_count(8);
        for (int i = 0; i < 7; i++) begin
            apply(1, 0, 15, i == 1, 3, 2, 0);
            check("t4_frozen_count", 32'(count), 32'd8);
            check("t4_frozen_wrap", 32'(wrap), 32'd0);
            check("t4_frozen_hit", 32'(hit), 32'b0100);
            step();
        end
        idle();
        check("t4_pending", 32'(cfg_bus.cfg_ready), 32'd0);
        wait_count(0);
        check("t4_committed", 32'(cfg_bus.cfg_ready), 32'd1);
        wait_count(1);
        check("t4_hit3_c1", 32'(hit[3]), 32'd0);
        wait_count(2);
        check("t4_hit3_c2", 32'(hit[3]), 32'd1);

        // period shrinks below count
        wait_count(9);
        cur_period = 4;
        idle();
        check("t5_forced_wrap", 32'(wrap), 32'd1);
        step();
        idle();
        check("t5_count0", 32'(count), 32'd0);
        wait_count(3);
        check("t5_wrap_c3", 32'(wrap), 32'd1);
        step();
        idle();
        check("t5_count0_again", 32'(count), 32'd0);

        // reset discards a pending update
        cur_period = 15;
        apply(1, 1, 15, 1, 0, 7, 0);
        step();
        idle();
        check("t6_pending", 32'(cfg_bus.cfg_ready), 32'd0);
        apply(0, 1, 15, 0, 0, 0, 0);
        step();
        idle();
        check("t6_count", 32'(count), 32'd0);
        check("t6_ready", 32'(cfg_bus.cfg_ready), 32'd1);
        check("t6_hit", 32'(hit), 32'hF);
        wait_count(14);
        step();
        wait_count(3);
        check("t6_ch0_div3", 32'(hit[0]), 32'd1);
`ifdef TICKER_STICKY_EN
        wait_count(0);
        apply(1, 1, 15, 0, 0, 0, 1);
        step();
        idle();
        check("t6_sticky_clr_wins", 32'(hit_sticky[0]), 32'd0);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            bit rn;
            bit v;
            if ($urandom_range(99) < 5) begin
                cur_period = ($urandom_range(99) < 2) ? 0 : int'($urandom_range(12, 1));
            end
            cur_en = ($urandom_range(99) < 85) ? 1 : 0;
            rn = ($urandom_range(99) != 0);
            v  = ($urandom_range(99) < 30);
            apply(rn, cur_en[0], cur_period, v, int'($urandom_range(NCH - 1)),
                  int'($urandom_range(6)), $urandom_range(99) < 5);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_divisor_ticker.md
# multi_divisor_ticker

Parametrised N-channel periodic tick generator. It runs one shared cycle counter that wraps at a runtime-programmable period. Per-channel phase counters assert `hit[i]` every `div[i]` counted cycles. Divisors are reprogrammed through a valid/ready port and take effect only at a period wrap, so every period is phase-coherent. It sits in the easy-block timing library as the generalised form of the fixed two-divisor fizz/buzz ticker.

## Interface
- `NUM_CH`, 4: number of divisor channels (1..16).
- `DIV_W`, 8: divisor and phase width.
- `CNT_W`, 8: shared counter and period width.
- `RESET_DIV`, 3: divisor loaded into every channel at reset (0..2^DIV_W-1).

- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `en` in 1: advance enable. When low, all state except the config port is frozen.
- `period` in `CNT_W`: wrap length, sampled every cycle. 0 means 2^`CNT_W`.
- `cfg_valid` in 1: divisor update request.
- `cfg_ready` out 1: update slot free.
- `cfg_ch` in clog2(`NUM_CH`) (min 1): target channel.
- `cfg_div` in `DIV_W`: new divisor.
- `count` out `CNT_W`: shared counter.
- `wrap` out 1: counter wraps on this edge.
- `hit` out `NUM_CH`: per-channel tick.
- `all_hit` out 1: every enabled channel hits this cycle.

## Operation
- Reset values: `count`=0, all phases=0, all `div`=`RESET_DIV`, pending slot empty.
  - Outputs immediately after reset: `cfg_ready`=1, `wrap`=0 (unless `period`=1), `hit[i]`=(`RESET_DIV`!=0), `all_hit`=(`RESET_DIV`!=0).
- `wrap` = `en` && (`count` >= eff_period-1), where eff_period is `period`, or 2^`CNT_W` when `period` is 0.
  - `>=` ensures that shrinking `period` below `count` forces a wrap on the next enabled cycle.
- On an enabled edge:
  - If `wrap`: `count`<=0 and all phases<=0.
  - Otherwise: `count`<=`count`+1, and each phase<=(phase==div-1) ? 0 : phase+1.
- `hit[i]` = (`div[i]`!=0) && (phase[i]==0). It is combinational from registers.
  - `div`=0 disables the channel.
  - `div`=1 hits every cycle.
- `all_hit` = OR(`div`!=0) && AND over i of (`div[i]`==0 || `hit[i]`).
- Config handshake:
  - `cfg_ready` = !pending.
  - A transfer occurs when `cfg_valid` && `cfg_ready`; `cfg_ch`/`cfg_div` are captured into the single shadow slot and pending is set.
  - Out-of-range `cfg_ch` (>=`NUM_CH`) is accepted and discarded on commit.
  - `cfg_valid` is honoured even while `en`=0.
- Commit: on an edge with `wrap`=1 and pending=1, `div[cfg_ch]`<=shadow and pending<=0.
  - If a handshake and a wrap with pending=0 occur on the same edge, that transfer waits for the next wrap (capture only).
- `resetn` low mid-operation discards any pending update; the handshake is not completed.

## Timing
- `hit`, `all_hit`, `wrap` and `count` have zero latency relative to register state.
- Config accepted at edge t, with the next wrap at edge w>t:
  - The new divisor is visible from cycle w+1 onward, with phase 0 (`hit`=1 if the new divisor is non-zero).
  - `cfg_ready` returns high in cycle w+1.
- With `en` held low, the outputs remain constant. `hit` stays asserted if it was asserted.
- Throughput: at most one divisor update per period.

## Configuration
- `TICKER_STICKY_EN` defined adds two ports:
  - input `sticky_clr` (1 bit);
  - output `hit_sticky[NUM_CH]`.
- `hit_sticky[i]` is set on any enabled edge where `hit[i]`=1, and cleared to 0 by reset or `sticky_clr`. Clear has priority over a simultaneous set.
- Undefined: those ports and registers are absent; all other behaviour is identical.

## Structure
- `ticker_pkg` holds:
  - default parameter constants (`TICKER_NUM_CH`, `TICKER_DIV_W`, `TICKER_CNT_W`, `TICKER_RESET_DIV`);
  - the `cfg_req_t` struct {ch, div};
  - the eff_period function.
- Sub-module `ticker_channel` implements one phase counter with its `div` register, commit input and `hit` output. It is instantiated `NUM_CH` times by generate. The shared counter, shadow slot and all_hit reduction stay in the top level.

## Test plan
- Reset with defaults, `period`=15, `en`=1. Channels 0-3 all use div 3: `hit`=4'hF at counts 0, 3, 6, 9, 12; `wrap` asserts at count 14, then count returns to 0.
- Config ch1 div 5 at count 4, `period`=15. `cfg_ready` drops; ch1 keeps div 3 until the wrap; after the wrap ch1 hits at counts 0, 5, 10; `cfg_ready`=1 at count 0.
- Config ch2 div 0 then div 1 across two periods. After the first wrap `hit[2]`=0 permanently and `all_hit` ignores ch2; after the second wrap `hit[2]`=1 every cycle.
- `en` low for 7 cycles at count 8. `count`, `hit`, `wrap` frozen; a config issued during this window is accepted and commits only at the eventual wrap.
- `period` changed 15->4 while `count`=9. `wrap`=1 on that cycle, count goes to 0 next, then wraps every 4 cycles.
- `resetn` pulsed while pending=1 (ch0 div 7). After reset ch0 stays at div 3, `cfg_ready`=1 and `count`=0. With `TICKER_STICKY_EN`: `sticky_clr` and `hit[0]` together leave `hit_sticky[0]`=0.
